// File: rtl/fft_pkg.sv
// Shared types and widths for the FFT datapath front end.
// Samples are packed complex values {re, im}, two's complement halves.
package fft_pkg;

  localparam int SAMPLE_W = 16;
  localparam int HALF_W   = 8;
  localparam int TW_BITS  = 2;

  typedef struct packed {
    logic signed [HALF_W-1:0] re;
    logic signed [HALF_W-1:0] im;
  } sample_t;

  typedef enum logic {
    FILL = 1'b0,
    PAIR = 1'b1
  } state_t;

endpackage

// File: rtl/fft_hold_buf.sv
// Register file that holds the first half of a butterfly block.
// One synchronous write port and one combinational read port.
module fft_hold_buf #(
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock_c,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: the storage array is deliberately not reset; every entry is written
  // before it is read within a block, so a reset would only add muxes.
  always_ff @(posedge clock_c) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_pair_feeder.sv
// Pairs x[k] with x[k+SPAN] for the radix-2 butterfly; holds the first SPAN
// samples of each block and emits one registered operand pair per later sample.
module fft_pair_feeder
  import fft_pkg::*;
#(
  parameter int DW      = fft_pkg::SAMPLE_W,
  parameter int SPAN    = 4,
  parameter int TW_BITS = fft_pkg::TW_BITS
) (
  input  logic               clock_c,
  input  logic               reset_n,
  input  logic [DW-1:0]      in_data,
  input  logic               in_valid,
  input  logic               in_sof,
  output logic [DW-1:0]      bf_a,
  output logic [DW-1:0]      bf_b,
  output logic [TW_BITS-1:0] bf_tw,
  output logic               bf_en,
  output logic               bf_last,
  output logic               sync_err
);

  localparam int CNT_W = $clog2(SPAN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SPAN - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               at_last;

  logic               buf_we;
  logic [CNT_W-1:0]   buf_waddr;
  logic [DW-1:0]      held;

  logic [DW-1:0]      bf_a_d, bf_b_d;
  logic [TW_BITS-1:0] bf_tw_d;
  logic               bf_en_d, bf_last_d, sync_err_d;

  fft_hold_buf #(
    .DW    (DW),
    .DEPTH (SPAN)
  ) u_hold_buf (
    .clock_c (clock_c),
    .we      (buf_we),
    .waddr   (buf_waddr),
    .wdata   (in_data),
    .raddr   (cnt_q),
    .rdata   (held)
  );

  assign at_last = (cnt_q == CNT_MAX);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_we     = 1'b0;
    buf_waddr  = cnt_q;
    bf_a_d     = bf_a;
    bf_b_d     = bf_b;
    bf_tw_d    = bf_tw;
    bf_en_d    = 1'b0;
    bf_last_d  = 1'b0;
    sync_err_d = sync_err;

    if (in_valid && reset_n) begin
      if (in_sof) begin
        // Start of block always re-aligns to index 0; a misaligned one is flagged.
        state_d   = FILL;
        cnt_d     = CNT_W'(1);
        buf_we    = 1'b1;
        buf_waddr = '0;
        if (state_q != FILL || cnt_q != '0) sync_err_d = 1'b1;
      end else begin
        cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
        unique case (state_q)
          FILL: begin
            buf_we = 1'b1;
            if (at_last) state_d = PAIR;
          end
          PAIR: begin
            bf_a_d    = held;
            bf_b_d    = in_data;
            // Top TW_BITS of the pair index select the twiddle.
            bf_tw_d   = cnt_q[CNT_W-1 -: TW_BITS];
            bf_en_d   = 1'b1;
            bf_last_d = at_last;
            if (at_last) state_d = FILL;
          end
          default: state_d = FILL;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock_c) begin
    if (!reset_n) begin
      state_q  <= FILL;
      cnt_q    <= '0;
      bf_a     <= '0;
      bf_b     <= '0;
      bf_tw    <= '0;
      bf_en    <= 1'b0;
      bf_last  <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bf_a     <= bf_a_d;
      bf_b     <= bf_b_d;
      bf_tw    <= bf_tw_d;
      bf_en    <= bf_en_d;
      bf_last  <= bf_last_d;
      sync_err <= sync_err_d;
    end
  end

endmodule

// File: tb/tb_fft_pair_feeder.sv
// Bench for fft_pair_feeder: SPAN=4 and SPAN=8 instances share one stimulus
// stream and are compared every cycle against a block-position reference model.
module tb_fft_pair_feeder;
  import fft_pkg::*;

  logic        clock_c = 1'b0;
  logic        reset_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_sof;

  logic [15:0] bf_a4, bf_b4, bf_a8, bf_b8;
  logic [1:0]  bf_tw4, bf_tw8;
  logic        bf_en4, bf_last4, sync_err4;
  logic        bf_en8, bf_last8, sync_err8;

  always #5 clock_c = ~clock_c;

  fft_pair_feeder #(.DW(16), .SPAN(4), .TW_BITS(2)) u_dut4 (
    .clock_c (clock_c), .reset_n (reset_n), .in_data (in_data),
    .in_valid (in_valid), .in_sof (in_sof),
    .bf_a (bf_a4), .bf_b (bf_b4), .bf_tw (bf_tw4), .bf_en (bf_en4),
    .bf_last (bf_last4), .sync_err (sync_err4)
  );

  fft_pair_feeder #(.DW(16), .SPAN(8), .TW_BITS(2)) u_dut8 (
    .clock_c (clock_c), .reset_n (reset_n), .in_data (in_data),
    .in_valid (in_valid), .in_sof (in_sof),
    .bf_a (bf_a8), .bf_b (bf_b8), .bf_tw (bf_tw8), .bf_en (bf_en8),
    .bf_last (bf_last8), .sync_err (sync_err8)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          tw;
    logic        last;
  } pulse_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: position within the 2*SPAN-sample block, plus held samples.
  int          pos    [2];
  logic [15:0] held   [2][8];
  logic [15:0] m_a    [2];
  logic [15:0] m_b    [2];
  logic [1:0]  m_tw   [2];
  logic        m_en   [2];
  logic        m_last [2];
  logic        m_err  [2];

  pulse_t log4[$];
  pulse_t log8[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int span_of(input int i);
    return (i == 0) ? 4 : 8;
  endfunction

  function automatic logic [15:0] smp(input int i);
    sample_t s;
    s.re = 8'(i);
    s.im = 8'(i);
    return s;
  endfunction

  task automatic model_update(input int i, input logic v, input logic s,
                              input logic [15:0] d, input logic r);
    int span = span_of(i);
    int k;
    m_en[i]   = 1'b0;
    m_last[i] = 1'b0;
    if (!r) begin
      pos[i] = 0;
      m_a[i] = '0; m_b[i] = '0; m_tw[i] = '0; m_err[i] = 1'b0;
    end else if (v) begin
      if (s) begin
        if (pos[i] != 0) m_err[i] = 1'b1;
        held[i][0] = d;
        pos[i] = 1;
      end else if (pos[i] < span) begin
        held[i][pos[i]] = d;
        pos[i]++;
      end else begin
        k = pos[i] - span;
        m_a[i]    = held[i][k];
        m_b[i]    = d;
        m_tw[i]   = 2'(k * 4 / span);
        m_en[i]   = 1'b1;
        m_last[i] = (k == span - 1);
        pos[i]    = (pos[i] + 1) % (2 * span);
      end
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [15:0] d, input logic r);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    reset_n  = r;
    @(posedge clock_c);
    for (int i = 0; i < 2; i++) model_update(i, v, s, d, r);
    #1;
    check("a4",    bf_a4,     m_a[0]);
    check("b4",    bf_b4,     m_b[0]);
    check("tw4",   bf_tw4,    m_tw[0]);
    check("en4",   bf_en4,    m_en[0]);
    check("last4", bf_last4,  m_last[0]);
    check("err4",  sync_err4, m_err[0]);
    check("a8",    bf_a8,     m_a[1]);
    check("b8",    bf_b8,     m_b[1]);
    check("tw8",   bf_tw8,    m_tw[1]);
    check("en8",   bf_en8,    m_en[1]);
    check("last8", bf_last8,  m_last[1]);
    check("err8",  sync_err8, m_err[1]);
    if (bf_en4) log4.push_back('{bf_a4, bf_b4, int'(bf_tw4), bf_last4});
    if (bf_en8) log8.push_back('{bf_a8, bf_b8, int'(bf_tw8), bf_last8});
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    log4.delete();
    log8.delete();
  endtask

  // Compare logged SPAN=4 pulses against pairs (first+k, first+4+k), tw=k.
  task automatic check_log4(input string tag, input int first, input int n);
    check({tag, "_cnt"}, log4.size(), n);
    for (int k = 0; k < n && k < log4.size(); k++) begin
      check({tag, "_a"},    log4[k].a,    smp(first + (k / 4) * 8 + k % 4));
      check({tag, "_b"},    log4[k].b,    smp(first + (k / 4) * 8 + k % 4 + 4));
      check({tag, "_tw"},   log4[k].tw,   k % 4);
      check({tag, "_last"}, log4[k].last, (k % 4) == 3);
    end
  endtask

  initial begin
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    reset_n  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pos[i] = 0; m_a[i] = '0; m_b[i] = '0; m_tw[i] = '0;
      m_en[i] = 1'b0; m_last[i] = 1'b0; m_err[i] = 1'b0;
    end

    // Reset state, then one back-to-back block.
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, i == 1, smp(i), 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    check_log4("t1", 1, 4);

    // Same block with idle cycles between samples.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, i == 1, smp(i), 1'b1);
      step(1'b0, 1'b0, 16'hdead, 1'b1);
    end
    check_log4("t2", 1, 4);

    // Two blocks back-to-back.
    do_reset();
    for (int i = 1; i <= 16; i++) step(1'b1, i == 1 || i == 9, smp(i), 1'b1);
    check_log4("t3", 1, 8);
    check("t3_err", sync_err4, 1'b0);

    // Misaligned start of block on the 6th sample.
    do_reset();
    for (int i = 1; i <= 5; i++) step(1'b1, i == 1, smp(i), 1'b1);
    log4.delete();
    step(1'b1, 1'b1, smp(20), 1'b1);
    check("t4_err", sync_err4, 1'b1);
    check("t4_nopulse", bf_en4, 1'b0);
    for (int i = 21; i <= 27; i++) step(1'b1, 1'b0, smp(i), 1'b1);
    check_log4("t4", 20, 4);

    // Reset in the middle of a block drops it.
    do_reset();
    for (int i = 1; i <= 6; i++) step(1'b1, i == 1, smp(i), 1'b1);
    log4.delete();
    step(1'b1, 1'b0, smp(7), 1'b0);
    check("t5_a", bf_a4, 16'h0);
    check("t5_en", bf_en4, 1'b0);
    for (int i = 8; i <= 11; i++) step(1'b1, 1'b0, smp(i), 1'b1);
    check("t5_cnt", log4.size(), 0);

    // SPAN=8: a single 16-sample block.
    do_reset();
    for (int i = 1; i <= 16; i++) step(1'b1, i == 1, smp(i), 1'b1);
    check("t6_cnt", log8.size(), 8);
    for (int k = 0; k < 8 && k < log8.size(); k++) begin
      check("t6_a",  log8[k].a,  smp(k + 1));
      check("t6_b",  log8[k].b,  smp(k + 9));
      check("t6_tw", log8[k].tw, k / 2);
    end

    // Randomized traffic: gaps, mostly aligned sof, occasional stray sof and reset.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic v, s, r;
      v = ($urandom_range(0, 99) < 75);
      s = (pos[0] == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 99) < 2);
      r = ($urandom_range(0, 199) != 0);
      step(v, s, 16'($urandom), r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
